// File: rtl/sbp_stage_mem_arbiter_if.sv
// Lookup, update-bus and RAM-port signals of one stage memory arbiter.
// Optional statistics counters are present when SBP_MEM_ARB_STATS_EN is defined.
interface sbp_stage_mem_arbiter_if #(
  parameter int unsigned STAGE_BITS = 6,
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DATA_BITS  = 64
);
  logic                  lk_read_i;
  logic [ADDR_BITS-1:0]  lk_addr_i;
  logic                  upd_valid_i;
  logic                  upd_ready_o;
  logic [STAGE_BITS-1:0] upd_stage_i;
  logic [ADDR_BITS-1:0]  upd_addr_i;
  logic [DATA_BITS-1:0]  upd_data_i;
  logic                  upd_done_o;
  logic                  stall_req_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_BITS-1:0]  mem_addr_o;
  logic [DATA_BITS-1:0]  mem_wdata_o;
`ifdef SBP_MEM_ARB_STATS_EN
  logic [15:0]           wr_count_o;
  logic [15:0]           stall_count_o;
`endif

  modport master (
    output lk_read_i, lk_addr_i, upd_valid_i, upd_stage_i, upd_addr_i, upd_data_i,
    input  upd_ready_o, upd_done_o, stall_req_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
`ifdef SBP_MEM_ARB_STATS_EN
    , input wr_count_o, stall_count_o
`endif
  );

  modport slave (
    input  lk_read_i, lk_addr_i, upd_valid_i, upd_stage_i, upd_addr_i, upd_data_i,
    output upd_ready_o, upd_done_o, stall_req_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
`ifdef SBP_MEM_ARB_STATS_EN
    , output wr_count_o, stall_count_o
`endif
  );
endinterface

// File: rtl/sbp_stage_mem_arbiter.sv
// Shares one stage RAM port between lookup reads (priority) and queued node writes.
// Define SBP_MEM_ARB_STATS_EN to add saturating write/stall counters.
module sbp_stage_mem_arbiter #(
  parameter int unsigned STAGE_ID   = 1,
  parameter int unsigned STAGE_BITS = 6,
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DATA_BITS  = 64,
  parameter int unsigned MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sbp_stage_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PEND, STALL} state_t;

  state_t                 state, next_state;
  logic [ADDR_BITS-1:0]   hold_addr;
  logic [DATA_BITS-1:0]   hold_data;
  logic [7:0]             wait_cnt, wait_next;
  logic                   ready, accept, write_issue, done_q;

  always_comb begin
    next_state  = state;
    wait_next   = wait_cnt;
    write_issue = 1'b0;
    ready       = (state == IDLE) && (bus.upd_stage_i == STAGE_BITS'(STAGE_ID)) && !rst;
    accept      = bus.upd_valid_i && ready;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = PEND;
          wait_next  = '0;
        end
      end
      PEND: begin
        if (!bus.lk_read_i) begin
          write_issue = 1'b1;
          next_state  = IDLE;
        end else begin
          wait_next = wait_cnt + 8'd1;
          if (wait_cnt == 8'(MAX_WAIT - 1)) next_state = STALL;
        end
      end
      STALL: begin
        if (!bus.lk_read_i) begin
          write_issue = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en_o   = 1'b0;
    bus.mem_we_o   = 1'b0;
    bus.mem_addr_o = '0;
    if (bus.lk_read_i) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_addr_o = bus.lk_addr_i;
    end else if (state != IDLE) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_we_o   = !rst;
      bus.mem_addr_o = hold_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
      done_q   <= write_issue;
      if (accept) begin
        hold_addr <= bus.upd_addr_i;
        hold_data <= bus.upd_data_i;
      end
    end
  end

  // stall request is a pure decode of the state register, so it is glitch-free
  // and clears with the async reset.
  assign bus.stall_req_o = (state == STALL);
  assign bus.upd_ready_o = ready;
  assign bus.upd_done_o  = done_q;
  assign bus.mem_wdata_o = hold_data;

`ifdef SBP_MEM_ARB_STATS_EN
  logic [15:0] wr_count, stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (write_issue && wr_count != '1) wr_count <= wr_count + 16'd1;
      if (state == PEND && next_state == STALL && stall_count != '1)
        stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.wr_count_o    = wr_count;
  assign bus.stall_count_o = stall_count;
`endif
endmodule

// File: doc/sbp_stage_mem_arbiter.md
Name: sbp_stage_mem_arbiter

Overview:
- Per-stage arbiter for the single-port stage memory of one lookup stage.
- Shares the RAM port between the lookup pipeline's read (always priority) and control-plane node writes arriving on a broadcast update bus.
- A pending write waits for a natural pipeline bubble.
- If no bubble arrives within MAX_WAIT cycles, the block requests one from the ingress via stall_req_o.
- One instance per lookup stage, placed between the stage's read/addr outputs and its RAM.

Parameters:
- STAGE_ID, 1, stage number this instance serves; compared against upd_stage_i.
- STAGE_BITS, 6, width of the stage id field.
- ADDR_BITS, 11, stage memory address width.
- DATA_BITS, 64, stage memory word width (node word).
- MAX_WAIT, 16, cycles a pending write may be blocked by lookups before stall_req_o asserts; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- lk_read_i  in  1  lookup stage read request this cycle
- lk_addr_i  in  ADDR_BITS  lookup read address
- upd_valid_i  in  1  update request valid (broadcast bus)
- upd_ready_o  out  1  update accepted when valid & ready
- upd_stage_i  in  STAGE_BITS  target stage of the update
- upd_addr_i  in  ADDR_BITS  node address to write
- upd_data_i  in  DATA_BITS  node word to write
- upd_done_o  out  1  one-cycle pulse, cycle after the write is issued
- stall_req_o  out  1  request to ingress to insert a bubble
- mem_en_o  out  1  RAM enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_BITS  RAM address
- mem_wdata_o  out  DATA_BITS  RAM write data

Behaviour:
- States: IDLE, PEND, STALL. Hold registers: hold_addr, hold_data, wait_cnt (8 bit).
- Reset (async, any state) → IDLE; hold regs 0; wait_cnt 0; upd_done_o 0; stall_req_o 0. A pending write is discarded and no done pulse is produced.
- RAM port mux (combinational, zero added latency):
  - lk_read_i=1: mem_en=1, we=0, addr=lk_addr_i. Lookup always wins.
  - Else if state PEND or STALL: mem_en=1, we=1, addr=hold_addr (write issued this cycle).
  - Else: mem_en=0, we=0, addr=0.
  - mem_wdata_o = hold_data at all times.
  - During rst: writes suppressed (we=0); reads still pass through.
- upd_ready_o = (state==IDLE) && (upd_stage_i==STAGE_ID) && !rst. The top level ORs all stages' ready signals; exactly one stage matches per request.
- IDLE: on accept, latch addr/data, wait_cnt←0 → PEND. Earliest write is the cycle after accept.
- PEND:
  - lk_read_i=0 → write issued → IDLE.
  - lk_read_i=1 → wait_cnt+1; when wait_cnt reaches MAX_WAIT-1 in a blocked cycle → STALL, stall_req_o←1 (registered).
- STALL:
  - stall_req_o held at 1 while waiting.
  - First cycle with lk_read_i=0 → write issued → IDLE; stall_req_o←0 next cycle.
  - No timeout; the bubble is guaranteed by the ingress.
- upd_done_o: registered; 1 for exactly one cycle after every issued write.
- Never more than one write outstanding. A new accept is possible the cycle after the write (back-to-back updates: 2-cycle period minimum).
- MAX_WAIT=1: the first blocked cycle moves to STALL.
- Read data and read latency of the RAM are unchanged by this block.

Optional Feature:
- Macro SBP_MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs wr_count_o (16 bit): increments on each issued write.
  - Adds stall_count_o (16 bit): increments on each PEND→STALL transition.
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Idle write: lk_read_i=0; send upd stage=1, addr=0x005, data=0xDEADBEEF_00000001.
  - Accept at cycle t.
  - Write issued at t+1 (mem_we=1, addr=0x005).
  - upd_done_o=1 at t+2; stall_req_o never asserts.
- Wrong stage: upd_stage_i=2 with STAGE_ID=1 → upd_ready_o=0, no RAM write, state stays IDLE.
- Blocked then bubble: lk_read_i=1 for 5 cycles after accept, then 0.
  - Reads pass with addr=lk_addr_i during the 5 cycles.
  - Write issued on the first 0 cycle; stall_req_o stays 0 (5 < 16).
- Forced stall: MAX_WAIT=4, lk_read_i=1 continuously.
  - stall_req_o=1 after the 4th blocked cycle and held.
  - Drop lk_read_i for one cycle → write in that cycle, stall_req_o=0 next cycle.
  - stall_count_o=1 when stats are enabled.
- Reset mid-operation: assert rst while in STALL.
  - Outputs clear asynchronously (stall_req_o=0).
  - No write and no upd_done_o; after release, upd_ready_o=1 for a matching stage.
- Back-to-back: two updates, lk_read_i=0.
  - Accepts at t and t+2; writes at t+1 and t+3.
  - wr_count_o=2.
